// File: rtl/register_file_bist_pkg.sv
// register_file_bist_pkg: march element encoding and per-element tables for the March C- sequencer
package register_file_bist_pkg;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;
  typedef enum logic {PH_RD, PH_WR} phase_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  localparam logic [7:0] EL_DOWN   = 8'b0001_1000;
  localparam logic [7:0] EL_RD     = 8'b0011_1110;
  localparam logic [7:0] EL_WR     = 8'b0001_1111;
  localparam logic [7:0] EL_RD_INV = 8'b0001_0100;
  localparam logic [7:0] EL_WR_INV = 8'b0000_1010;
endpackage

// File: rtl/register_file_bist_cmp.sv
// register_file_bist_cmp: one-stage read compare pipeline with first-failure capture
module register_file_bist_cmp
  import register_file_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] exp,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  elem_e                 elem,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  hit,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [2:0]            err_elem,
  output logic [DATA_WIDTH-1:0] err_data
);
  logic                  vld;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  elem_e                 elem_q;
  assign hit = vld && (q != exp_q) && !fail;
  // carry the issued read one cycle, then latch only the first mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= 1'b0;
      exp_q    <= '0;
      addr_q   <= '0;
      elem_q   <= M0;
      fail     <= 1'b0;
      err_addr <= '0;
      err_elem <= '0;
      err_data <= '0;
    end else begin
      vld    <= rd;
      exp_q  <= exp;
      addr_q <= addr;
      elem_q <= elem;
      if (clr) begin
        fail     <= 1'b0;
        err_addr <= '0;
        err_elem <= '0;
        err_data <= '0;
      end else if (hit) begin
        fail     <= 1'b1;
        err_addr <= addr_q;
        err_elem <= elem_q;
        err_data <= q;
      end
    end
  end
endmodule

// File: rtl/register_file_bist_ctrl.sv
// register_file_bist_ctrl: March C- BIST sequencer driving the register file test port
module register_file_bist_ctrl
  import register_file_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [2:0]            err_elem_o,
  output logic [DATA_WIDTH-1:0] err_data_o,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  output logic [NUM_BYTE-1:0]   be_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i
);
  localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;
  state_e                st, st_n;
  elem_e                 elem, elem_n;
  phase_e                ph, ph_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] pat;
  logic                  accept, run, wr, last_op, term, hit, cfail;
  logic                  done_q, pass_q, fail_q;
  assign accept  = (st == S_IDLE) && start_i;
  assign run     = (st == S_RUN);
  assign wr      = run && (ph == PH_WR);
  assign last_op = (ph == PH_WR) || !EL_WR[elem];
  assign term    = EL_DOWN[elem] ? (addr == '0) : (addr == A_MAX);
  assign busy_o  = (st != S_IDLE);
  assign bist_o  = busy_o;
  assign done_o  = done_q;
  assign pass_o  = pass_q;
  assign fail_o  = fail_q;
  assign csn_t_o = !run;
  assign wen_t_o = !wr;
  assign a_t_o   = run ? addr : '0;
  assign d_t_o   = wr ? (EL_WR_INV[elem] ? ~pat : pat) : '0;
  assign be_t_o  = '1;
  // sequencer state, element, phase and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      elem <= M0;
      ph   <= PH_WR;
      addr <= '0;
    end else begin
      st   <= st_n;
      elem <= elem_n;
      ph   <= ph_n;
      addr <= addr_n;
    end
  end
  // march walk: RD->WR within an address, step address, then next element or drain
  always_comb begin
    st_n   = st;
    elem_n = elem;
    ph_n   = ph;
    addr_n = addr;
    if (accept) begin
      st_n   = S_RUN;
      elem_n = M0;
      ph_n   = PH_WR;
      addr_n = '0;
    end else if (st == S_DRAIN) begin
      st_n = S_IDLE;
    end else if (run) begin
      if (hit) st_n = S_DRAIN;
      else if (!last_op) ph_n = PH_WR;
      else if (!term) begin
        addr_n = EL_DOWN[elem] ? addr - 1'b1 : addr + 1'b1;
        ph_n   = EL_RD[elem] ? PH_RD : PH_WR;
      end else if (elem == M5) st_n = S_DRAIN;
      else begin
        elem_n = elem_e'(elem + 3'd1);
        addr_n = EL_DOWN[elem_n] ? A_MAX : '0;
        ph_n   = EL_RD[elem_n] ? PH_RD : PH_WR;
      end
    end
  end
  // background latch and end-of-test status, settled as the drain cycle closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat    <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      done_q <= (st == S_DRAIN);
      if (accept) begin
        pat    <= pattern_i;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end else if (st == S_DRAIN) begin
        pass_q <= !(cfail || hit);
        fail_q <= cfail || hit;
      end
    end
  end
  register_file_bist_cmp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .rd       (run && (ph == PH_RD)),
    .exp      (EL_RD_INV[elem] ? ~pat : pat),
    .addr     (addr),
    .elem     (elem),
    .q        (q_t_i),
    .hit      (hit),
    .fail     (cfail),
    .err_addr (err_addr_o),
    .err_elem (err_elem_o),
    .err_data (err_data_o)
  );
endmodule

// File: tb/tb_register_file_bist_ctrl.sv
// tb_register_file_bist_ctrl: directed March C- runs against behavioural register file models
module tb_register_file_bist_ctrl;
  logic        clk = 0;
  logic        rst_n, start, start1;
  logic [31:0] pat, pat1;
  logic        busy, done, pass, fail, bist, csn, wen;
  logic [4:0]  err_addr, a;
  logic [2:0]  err_elem, err_elem1;
  logic [31:0] err_data, d, q;
  logic [3:0]  be, be1;
  logic        busy1, done1, pass1, fail1, bist1, csn1, wen1;
  logic [0:0]  err_addr1, a1;
  logic [31:0] err_data1, d1, q1;
  logic [31:0] mem [32];
  logic [31:0] mem1 [2];
  logic        stuck_en, coup_en;
  int          vectors, miscompares, busy_cnt, cs_cnt, n;
  logic [19:0] seq_a, seq_w;

  always #5 clk = ~clk;

  register_file_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .pattern_i(pat), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_o(fail), .err_addr_o(err_addr), .err_elem_o(err_elem), .err_data_o(err_data),
    .bist_o(bist), .csn_t_o(csn), .wen_t_o(wen), .a_t_o(a), .d_t_o(d), .be_t_o(be), .q_t_i(q)
  );

  register_file_bist_ctrl #(.ADDR_WIDTH(1), .DATA_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .pattern_i(pat1), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .fail_o(fail1), .err_addr_o(err_addr1), .err_elem_o(err_elem1), .err_data_o(err_data1),
    .bist_o(bist1), .csn_t_o(csn1), .wen_t_o(wen1), .a_t_o(a1), .d_t_o(d1), .be_t_o(be1), .q_t_i(q1)
  );

  function automatic logic [31:0] bmask(input logic [3:0] b);
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{b[i]}};
  endfunction

  // register file model: sync write, 1-cycle read, optional stuck-at and coupling faults
  always @(posedge clk) begin
    if (!csn) begin
      if (!wen) begin
        mem[a] <= (mem[a] & ~bmask(be)) | (d & bmask(be));
        if (coup_en && a == 5'd4) mem[5] <= mem[5] ^ 32'h1;
      end else q <= mem[a] | ((stuck_en && a == 5'd7) ? 32'h8 : 32'h0);
    end
    if (!csn1) begin
      if (!wen1) mem1[a1] <= (mem1[a1] & ~bmask(be1)) | (d1 & bmask(be1));
      else q1 <= mem1[a1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run0(input logic [31:0] p, input bit inj);
    busy_cnt = 0;
    cs_cnt = 0;
    n = 0;
    start = 1;
    pat = p;
    @(negedge clk);
    start = 0;
    while (!done && n < 4000) begin
      busy_cnt += busy;
      cs_cnt += !csn;
      start = inj && (busy_cnt == 10 || busy_cnt == 100);
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("done_seen", done, 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 0;
    start = 0;
    start1 = 0;
    pat = 0;
    pat1 = 0;
    stuck_en = 0;
    coup_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy_bist_done", {busy, bist, done}, 3'b000);
    chk("rst_pass_fail", {pass, fail}, 2'b00);
    chk("rst_csn_wen", {csn, wen}, 2'b11);
    chk("rst_be", be, 4'hf);
    chk("rst_a_d", {a, d}, 37'h0);
    chk("rst_err", {err_addr, err_elem, err_data}, 40'h0);
    rst_n = 1;
    @(negedge clk);
    run0(32'h0, 0);
    chk("t1_busy", busy_cnt, 321);
    chk("t1_cs", cs_cnt, 320);
    chk("t1_pass_fail", {pass, fail, busy, bist}, 4'b1000);
    @(negedge clk);
    chk("t1_done_width", done, 0);
    stuck_en = 1;
    run0(32'h0, 0);
    chk("t2_fail", {pass, fail}, 2'b01);
    chk("t2_err_elem", err_elem, 1);
    chk("t2_err_addr", err_addr, 7);
    chk("t2_err_data", err_data, 32'h8);
    chk("t2_busy", busy_cnt, 49);
    chk("t2_cs", cs_cnt, 48);
    stuck_en = 0;
    @(negedge clk);
    coup_en = 1;
    run0(32'hA5A5_A5A5, 0);
    chk("t3_fail", {pass, fail}, 2'b01);
    chk("t3_err", {err_elem, err_addr}, {3'd1, 5'd5});
    chk("t3_err_data", err_data, 32'hA5A5_A5A4);
    chk("t3_busy", busy_cnt, 45);
    coup_en = 0;
    @(negedge clk);
    run0(32'h0, 1);
    chk("t4_busy_ignored_starts", busy_cnt, 321);
    chk("t4_pass", {pass, fail}, 2'b10);
    run0(32'h3C3C_0FF0, 0);
    chk("t4_restart_busy", busy_cnt, 321);
    chk("t4_restart_pass", {pass, fail}, 2'b10);
    @(negedge clk);
    start = 1;
    pat = 32'h1234_5678;
    @(negedge clk);
    start = 0;
    repeat (149) @(negedge clk);
    chk("t5_busy_before_rst", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_busy_bist", {busy, bist, done, pass, fail}, 5'b00000);
    chk("t5_rst_port", {csn, wen, be, a, d}, {2'b11, 4'hf, 37'h0});
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run0(32'hFFFF_0000, 0);
    chk("t5_rerun_busy", busy_cnt, 321);
    chk("t5_rerun_pass", {pass, fail}, 2'b10);
    busy_cnt = 0;
    seq_a = 0;
    seq_w = 0;
    n = 0;
    start1 = 1;
    pat1 = 32'hFFFF_FFFF;
    @(negedge clk);
    start1 = 0;
    while (!done1 && n < 200) begin
      busy_cnt += busy1;
      if (!csn1) begin
        seq_a = {seq_a[18:0], a1};
        seq_w = {seq_w[18:0], wen1};
      end
      @(negedge clk);
      n++;
    end
    chk("t6_done_seen", done1, 1);
    chk("t6_busy", busy_cnt, 21);
    chk("t6_addr_seq", seq_a, 20'b01_0011_0011_1100_1100_01);
    chk("t6_wen_seq", seq_w, 20'b00_1010_1010_1010_1010_11);
    chk("t6_pass", {pass1, fail1}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
